// File: rtl/counter_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : counter_sequencer
// Description : Run controller for the 8-bit display counter. A rate divider
//               produces one-cycle advance events; a four-state
//               IDLE/RUN/PAUSE/HALT FSM decides when the count advances and
//               what happens at terminal count (wrap to 0 or halt at 255).
//               The 8-bit count register supports parallel load.
// Ports       : clk      - single clock, rising-edge
//               reset    - asynchronous active-high reset
//               start    - run / resume request (level, re-sampled each edge)
//               stop     - pause / stop request (beats start)
//               rate     - tick period select (00:1, 01:B, 10:2B, 11:4B)
//               load     - parallel load request (highest priority)
//               load_val - value loaded into count
//               wrap     - 1: wrap 255->0, 0: halt at 255
//               count    - registered count (low nibble HEX0, high HEX1)
//               tick     - high for the cycle after an edge that advanced count
//               busy     - state is RUN
//               done     - state is HALT
// Revision    : 1.0 - initial release
// ============================================================================
module counter_sequencer #(
    parameter int BASE_DIV = 50_000_000,
    parameter int DIV_W    = $clog2(4 * BASE_DIV)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic [1:0] rate,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       wrap,
    output logic [7:0] count,
    output logic       tick,
    output logic       busy,
    output logic       done
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_RUN   = 2'd1;
    localparam logic [1:0] c_ST_PAUSE = 2'd2;
    localparam logic [1:0] c_ST_HALT  = 2'd3;

    // Terminal divider values (L-1) for each rate setting
    localparam logic [DIV_W-1:0] c_LIM_M1_0 = '0;
    localparam logic [DIV_W-1:0] c_LIM_M1_1 = DIV_W'(BASE_DIV - 1);
    localparam logic [DIV_W-1:0] c_LIM_M1_2 = DIV_W'(2 * BASE_DIV - 1);
    localparam logic [DIV_W-1:0] c_LIM_M1_3 = DIV_W'(4 * BASE_DIV - 1);
    localparam logic [DIV_W-1:0] c_DIV_ONE  = DIV_W'(1);

    localparam logic [7:0] c_CNT_MAX = 8'hFF;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [1:0]       r_state;
    logic [DIV_W-1:0] r_div;
    logic [7:0]       r_count;
    logic             r_tick;
    logic [1:0]       r_rate_q;

    // ------------------------------------------------------------------------
    // Combinational next values
    // ------------------------------------------------------------------------
    logic [1:0]       w_state_nxt;
    logic [DIV_W-1:0] w_div_nxt;
    logic [7:0]       w_count_nxt;
    logic             w_tick_nxt;
    logic [DIV_W-1:0] w_lim_m1;
    logic             w_rate_chg;

    // Divider terminal value for the currently selected rate
    always_comb begin
        w_lim_m1 = c_LIM_M1_0;
        case (rate)
            2'b00:   w_lim_m1 = c_LIM_M1_0;
            2'b01:   w_lim_m1 = c_LIM_M1_1;
            2'b10:   w_lim_m1 = c_LIM_M1_2;
            default: w_lim_m1 = c_LIM_M1_3;
        endcase
    end

    assign w_rate_chg = (rate != r_rate_q);

    // ------------------------------------------------------------------------
    // Process 1: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath registers that travel with the state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div    <= '0;
            r_count  <= 8'd0;
            r_tick   <= 1'b0;
            r_rate_q <= 2'b00;
        end else begin
            r_div    <= w_div_nxt;
            r_count  <= w_count_nxt;
            r_tick   <= w_tick_nxt;
            r_rate_q <= rate;
        end
    end

    // ------------------------------------------------------------------------
    // Process 2: next-state / next-datapath logic
    // Priority at each edge: load, then stop, then start.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_div_nxt   = r_div;
        w_count_nxt = r_count;
        w_tick_nxt  = 1'b0;

        if (load) begin
            w_count_nxt = load_val;
            w_div_nxt   = '0;
            w_state_nxt = c_ST_IDLE;
        end else if (stop) begin
            case (r_state)
                // Pausing freezes the divider so resume continues the period
                c_ST_RUN:   w_state_nxt = c_ST_PAUSE;
                c_ST_PAUSE: begin
                    w_state_nxt = c_ST_IDLE;
                    w_div_nxt   = '0;
                end
                c_ST_HALT:  w_state_nxt = c_ST_IDLE;
                default:    w_state_nxt = r_state;
            endcase
        end else if (start && (r_state != c_ST_RUN)) begin
            case (r_state)
                c_ST_IDLE: begin
                    w_state_nxt = c_ST_RUN;
                    w_div_nxt   = '0;
                end
                // Resume: divider keeps its held value, no period restart
                c_ST_PAUSE: w_state_nxt = c_ST_RUN;
                c_ST_HALT: begin
                    w_state_nxt = c_ST_RUN;
                    w_count_nxt = 8'd0;
                    w_div_nxt   = '0;
                end
                default:    w_state_nxt = r_state;
            endcase
        end else if (r_state == c_ST_RUN) begin
            // A rate change restarts the period, so no terminal event this edge
            if (w_rate_chg) begin
                w_div_nxt = '0;
            end else if (r_div == w_lim_m1) begin
                w_div_nxt = '0;
                if (r_count != c_CNT_MAX) begin
                    w_count_nxt = r_count + 8'd1;
                    w_tick_nxt  = 1'b1;
                end else if (wrap) begin
                    w_count_nxt = 8'd0;
                    w_tick_nxt  = 1'b1;
                end else begin
                    w_state_nxt = c_ST_HALT;
                end
            end else begin
                w_div_nxt = r_div + c_DIV_ONE;
            end
        end

        // Rate change clears the divider in every state
        if (w_rate_chg) begin
            w_div_nxt = '0;
        end
    end

    // ------------------------------------------------------------------------
    // Process 3: output decode
    // ------------------------------------------------------------------------
    always_comb begin
        busy  = (r_state == c_ST_RUN);
        done  = (r_state == c_ST_HALT);
        tick  = r_tick;
        count = r_count;
    end

endmodule
`default_nettype wire

// File: tb/tb_counter_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_counter_sequencer
// Description : Self-checking bench for counter_sequencer (BASE_DIV = 4).
//               Table-driven vectors for single-edge behaviour plus
//               hand-written sequences for multi-cycle corner cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_counter_sequencer;

    localparam int c_BASE = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       stop;
    logic [1:0] rate;
    logic       load;
    logic [7:0] load_val;
    logic       wrap;
    logic [7:0] count;
    logic       tick;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_errors = 0;

    counter_sequencer #(
        .BASE_DIV(c_BASE)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .stop     (stop),
        .rate     (rate),
        .load     (load),
        .load_val (load_val),
        .wrap     (wrap),
        .count    (count),
        .tick     (tick),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       st;
        logic       sp;
        logic       ld;
        logic [7:0] lv;
        logic       wr;
        logic [1:0] rt;
        logic [7:0] e_cnt;
        logic       e_tick;
        logic       e_busy;
        logic       e_done;
    } vec_t;

    vec_t vecs[$];

    task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0b expected %0b", nm, act, exp);
        end
    endtask

    task automatic check_all(input string nm, input logic [7:0] ec, input logic et,
                             input logic eb, input logic ed);
        chk8({nm, ".count"}, count, ec);
        chk1({nm, ".tick"}, tick, et);
        chk1({nm, ".busy"}, busy, eb);
        chk1({nm, ".done"}, done, ed);
    endtask

    // Drive inputs on the falling edge, sample 1 time unit after the rising edge
    task automatic step(input logic st, input logic sp, input logic ld, input logic [7:0] lv,
                        input logic wr, input logic [1:0] rt);
        @(negedge clk);
        start    = st;
        stop     = sp;
        load     = ld;
        load_val = lv;
        wrap     = wr;
        rate     = rt;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input string nm, input logic st, input logic sp, input logic ld,
                       input logic [7:0] lv, input logic wr, input logic [1:0] rt,
                       input logic [7:0] ec, input logic et, input logic eb, input logic ed);
        vec_t v;
        v.name = nm; v.st = st; v.sp = sp; v.ld = ld; v.lv = lv; v.wr = wr; v.rt = rt;
        v.e_cnt = ec; v.e_tick = et; v.e_busy = eb; v.e_done = ed;
        vecs.push_back(v);
    endtask

    initial begin
        logic [7:0] exp_c;
        logic       exp_t;

        reset = 1'b1; start = 1'b0; stop = 1'b0; load = 1'b0;
        load_val = 8'h00; wrap = 1'b0; rate = 2'b00;

        //   name        st sp ld lv     wr rate   count  tk bs dn
        add("idle0",     0, 0, 0, 8'h00, 0, 2'b00, 8'h00, 0, 0, 0);
        add("r00_start", 1, 0, 0, 8'h00, 0, 2'b00, 8'h00, 0, 1, 0);
        add("r00_c1",    0, 0, 0, 8'h00, 0, 2'b00, 8'h01, 1, 1, 0);
        add("r00_c2",    0, 0, 0, 8'h00, 0, 2'b00, 8'h02, 1, 1, 0);
        add("r00_c3",    0, 0, 0, 8'h00, 0, 2'b00, 8'h03, 1, 1, 0);
        add("r00_pause", 0, 1, 0, 8'h00, 0, 2'b00, 8'h03, 0, 0, 0);
        add("r00_idle",  0, 1, 0, 8'h00, 0, 2'b00, 8'h03, 0, 0, 0);
        add("idle_stop", 0, 1, 0, 8'h00, 0, 2'b00, 8'h03, 0, 0, 0);
        add("h_load",    0, 0, 1, 8'hFE, 0, 2'b00, 8'hFE, 0, 0, 0);
        add("h_start",   1, 0, 0, 8'h00, 0, 2'b00, 8'hFE, 0, 1, 0);
        add("h_255",     0, 0, 0, 8'h00, 0, 2'b00, 8'hFF, 1, 1, 0);
        add("h_halt",    0, 0, 0, 8'h00, 0, 2'b00, 8'hFF, 0, 0, 1);
        add("h_hold",    0, 0, 0, 8'h00, 0, 2'b00, 8'hFF, 0, 0, 1);
        add("h_restart", 1, 0, 0, 8'h00, 0, 2'b00, 8'h00, 0, 1, 0);
        add("h_c1",      0, 0, 0, 8'h00, 0, 2'b00, 8'h01, 1, 1, 0);
        add("w_load",    0, 0, 1, 8'hFE, 1, 2'b00, 8'hFE, 0, 0, 0);
        add("w_start",   1, 0, 0, 8'h00, 1, 2'b00, 8'hFE, 0, 1, 0);
        add("w_255",     0, 0, 0, 8'h00, 1, 2'b00, 8'hFF, 1, 1, 0);
        add("w_wrap0",   0, 0, 0, 8'h00, 1, 2'b00, 8'h00, 1, 1, 0);
        add("w_stst",    1, 1, 0, 8'h00, 1, 2'b00, 8'h00, 0, 0, 0);
        add("w_resume",  1, 0, 0, 8'h00, 1, 2'b00, 8'h00, 0, 1, 0);
        add("w_c1",      0, 0, 0, 8'h00, 1, 2'b00, 8'h01, 1, 1, 0);
        add("w_ldstop",  0, 1, 1, 8'h5A, 1, 2'b00, 8'h5A, 0, 0, 0);
        add("s_load",    0, 0, 1, 8'hFF, 0, 2'b00, 8'hFF, 0, 0, 0);
        add("s_start",   1, 0, 0, 8'h00, 0, 2'b00, 8'hFF, 0, 1, 0);
        add("s_halt",    0, 0, 0, 8'h00, 0, 2'b00, 8'hFF, 0, 0, 1);
        add("s_stop",    0, 1, 0, 8'h00, 0, 2'b00, 8'hFF, 0, 0, 0);

        // Reset state
        #12;
        check_all("reset", 8'h00, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        // Table-driven section
        foreach (vecs[i]) begin
            step(vecs[i].st, vecs[i].sp, vecs[i].ld, vecs[i].lv, vecs[i].wr, vecs[i].rt);
            check_all(vecs[i].name, vecs[i].e_cnt, vecs[i].e_tick, vecs[i].e_busy, vecs[i].e_done);
        end

        // Rate 10 period (L = 8): count 1 at edge 8, 2 at edge 16
        step(0, 0, 1, 8'h00, 0, 2'b10);
        check_all("r10_load", 8'h00, 1'b0, 1'b0, 1'b0);
        step(1, 0, 0, 8'h00, 0, 2'b10);
        check_all("r10_e0", 8'h00, 1'b0, 1'b1, 1'b0);
        for (int k = 1; k <= 16; k++) begin
            step(0, 0, 0, 8'h00, 0, 2'b10);
            exp_c = (k >= 16) ? 8'h02 : ((k >= 8) ? 8'h01 : 8'h00);
            exp_t = (k == 8) || (k == 16);
            chk8($sformatf("r10_e%0d.count", k), count, exp_c);
            chk1($sformatf("r10_e%0d.tick", k), tick, exp_t);
        end

        // Pause at divider = 2 with rate 01 (L = 4), resume two edges before advance
        step(0, 0, 1, 8'h00, 0, 2'b01);
        step(1, 0, 0, 8'h00, 0, 2'b01);
        step(0, 0, 0, 8'h00, 0, 2'b01);
        step(0, 0, 0, 8'h00, 0, 2'b01);
        step(0, 1, 0, 8'h00, 0, 2'b01);
        check_all("p_pause", 8'h00, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            step(0, 0, 0, 8'h00, 0, 2'b01);
            chk8($sformatf("p_frozen%0d.count", k), count, 8'h00);
            chk1($sformatf("p_frozen%0d.busy", k), busy, 1'b0);
        end
        step(1, 0, 0, 8'h00, 0, 2'b01);
        check_all("p_resume", 8'h00, 1'b0, 1'b1, 1'b0);
        step(0, 0, 0, 8'h00, 0, 2'b01);
        check_all("p_div3", 8'h00, 1'b0, 1'b1, 1'b0);
        step(0, 0, 0, 8'h00, 0, 2'b01);
        check_all("p_adv", 8'h01, 1'b1, 1'b1, 1'b0);

        // Asynchronous reset mid-run with count 0x37
        step(0, 0, 1, 8'h36, 0, 2'b00);
        step(1, 0, 0, 8'h00, 0, 2'b00);
        step(0, 0, 0, 8'h00, 0, 2'b00);
        check_all("ar_pre", 8'h37, 1'b1, 1'b1, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        check_all("ar_async", 8'h00, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        step(0, 1, 0, 8'h00, 0, 2'b00);
        check_all("ar_stop", 8'h00, 1'b0, 1'b0, 1'b0);
        step(0, 0, 0, 8'h00, 0, 2'b00);
        check_all("ar_idle", 8'h00, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
